// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port byte memory between instruction fetch and load/store.
// One access in flight at a time; data wins ties unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic       owner_d;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       grant_d;

    // Fetch only overrides a pending data request once it has been passed over STARVE_MAX times.
    assign grant_d = d_req && (!if_req || (starve_cnt != STARVE_LIM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner_d    <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!if_req)
                        starve_cnt <= '0;
                    if (d_req || if_req) begin
                        owner_d <= grant_d;
                        mem_en  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_ISSUE;
                        if (grant_d) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            if (if_req && starve_cnt != STARVE_LIM)
                                starve_cnt <= starve_cnt + 4'd1;
                        end else begin
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            starve_cnt <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        // Read data is valid this cycle; stores leave d_rdata untouched.
                        if (!owner_d)
                            if_rdata <= mem_rdata;
                        else if (!mem_we)
                            d_rdata <= mem_rdata;
                        if_ack <= !owner_d;
                        d_ack  <= owner_d;
                        state  <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
